// File: rtl/shared_mem_port.sv
// shared_mem_port: issues the arbiter-granted requester's command on one shared memory port
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_grant, i_req, i_we    per-requester one-hot grant, request and write enable
//   i_addr, i_wdata         flat per-requester address / write data (requester k at slice k)
//   o_done                  one-cycle completion pulse on the served requester's bit
//   o_rdata                 read data, updated when a read completes and held until the next one
//   o_busy                  high whenever a transaction is in flight (not IDLE)
//   o_err_multi             sticky flag: a start saw more than one granted-and-requesting bit
//   o_mem_*, i_mem_*        shared memory port: valid/ready command channel, rvalid response
module shared_mem_port #(
    parameter int N_REQ  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_grant,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ-1:0]           i_we,
    input  logic [N_REQ*ADDR_W-1:0]    i_addr,
    input  logic [N_REQ*DATA_W-1:0]    i_wdata,
    output logic [N_REQ-1:0]           o_done,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_busy,
    output logic                       o_err_multi,
    output logic                       o_mem_valid,
    input  logic                       i_mem_ready,
    output logic                       o_mem_we,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [DATA_W-1:0]          o_mem_wdata,
    input  logic                       i_mem_rvalid,
    input  logic [DATA_W-1:0]          i_mem_rdata
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;
    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [N_REQ-1:0]  w_act;
    logic [IW-1:0]     w_idx;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_multi;
    assign w_act   = i_grant & i_req;
    assign w_multi = $countones(w_act) > 1;
    // Descending scan so the lowest active requester is the one selected.
    always_comb begin
        w_idx   = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_idx   = IW'(i);
                w_we    = i_we[i];
                w_addr  = i_addr[i*ADDR_W +: ADDR_W];
                w_wdata = i_wdata[i*DATA_W +: DATA_W];
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            o_done      <= '0;
            o_rdata     <= '0;
            o_busy      <= 1'b0;
            o_err_multi <= 1'b0;
            o_mem_valid <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_done <= '0;
            case (r_state)
                IDLE: if (|w_act) begin
                    r_idx       <= w_idx;
                    o_mem_we    <= w_we;
                    o_mem_addr  <= w_addr;
                    o_mem_wdata <= w_wdata;
                    o_mem_valid <= 1'b1;
                    o_busy      <= 1'b1;
                    r_state     <= CMD;
                    if (w_multi) o_err_multi <= 1'b1;
                end
                CMD: if (i_mem_ready) begin
                    o_mem_valid <= 1'b0;
                    if (o_mem_we) begin
                        o_done[r_idx] <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: if (i_mem_rvalid) begin
                    o_rdata       <= i_mem_rdata;
                    o_done[r_idx] <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
